instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Program loader that fills the 32-word instruction memory from a byte stream before the CPU runs. It is the write side of the instruction store; the CPU fetch path is the read side. It takes bytes over a valid/ready handshake and packs four bytes into each 32-bit instruction, first byte most significant, which matches the MSB-first order of the program text files. It writes each word to consecutive word-aligned byte addresses from 0, and holds the CPU in reset until loading completes.

Parameters:
MEM_WORDS, 32, instruction memory depth in words; upper bound on a load.
CNT_W, 6, width of the word-count input; must hold the value MEM_WORDS.

Ports:
clk_i  input  1  system clock; all state changes on the rising edge.
rst_i  input  1  synchronous, active-high reset.
start_i  input  1  load request; sampled only in IDLE.
word_cnt_i  input  CNT_W  number of words to load; latched on an accepted start.
byte_i  input  8  stream data byte.
byte_valid_i  input  1  byte_i is valid.
byte_ready_o  output  1  loader accepts a byte this cycle.
wr_en_o  output  1  one-cycle memory write strobe.
wr_addr_o  output  32  byte address of the write, always a multiple of 4.
wr_data_o  output  32  assembled instruction word.
busy_o  output  1  load in progress (LOAD or WRITE state).
done_o  output  1  last load completed; level signal.
err_o  output  1  last start was rejected; level signal.
cpu_hold_o  output  1  holds the CPU in reset; equals busy_o.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0: byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, err_o, cpu_hold_o.
  - Internal byte count, word index and shift register are cleared.
- Reset in mid-load: the partial word is discarded and no write is issued. Words already written stay in memory; the loader never clears memory.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - byte_ready_o=0; bytes offered here are not consumed.
  - On start_i=1 with 1 <= word_cnt_i <= MEM_WORDS: latch the count, clear done_o and err_o, clear the byte count and word index, go to LOAD.
  - On start_i=1 with word_cnt_i=0 or word_cnt_i > MEM_WORDS: set err_o=1, clear done_o, stay in IDLE.
- LOAD:
  - byte_ready_o=1 (registered; it rises the cycle after start is accepted).
  - A transfer occurs when byte_valid_i and byte_ready_o are both 1 at a clock edge.
  - On each transfer: shift register becomes {shift[23:0], byte_i}, and the byte count increments.
  - On the 4th transfer: go to WRITE, and byte_ready_o drops to 0 that same edge. At most 4 bytes are accepted per word.
  - byte_valid_i low means wait indefinitely; there is no timeout.
- WRITE (exactly one cycle):
  - wr_en_o=1, wr_addr_o = word_index*4, wr_data_o = assembled word.
  - Latency: the strobe is in the cycle right after the edge that took the 4th byte.
  - Then the word index increments and the byte count clears.
  - If the new index equals the latched count, go to DONE; otherwise go back to LOAD.
- wr_addr_o and wr_data_o hold their last values while wr_en_o=0.
- DONE:
  - Set done_o=1 and go to IDLE next cycle.
  - done_o stays 1 until the next accepted start, a rejected start, or reset.
- busy_o and cpu_hold_o are 1 in LOAD and WRITE, and 0 otherwise.
- start_i is ignored while busy_o=1. A new load never corrupts one in progress.
- The word index is never allowed past MEM_WORDS-1, so the highest address is 4*(MEM_WORDS-1) = 124.

Test Plan:
1. Reset with rst_i=1 for 2 cycles, stream driving valid bytes -> all outputs 0, and no byte consumed (byte_ready_o=0).
2. start_i with word_cnt_i=2, bytes 8C 01 00 04 20 22 18 2A with valid held high -> write (addr 0x0, data 0x8C010004), then write (addr 0x4, data 0x2022182A); each wr_en_o is exactly 1 cycle and comes 1 cycle after the 4th byte; done_o=1 afterwards; cpu_hold_o=1 throughout the load.
3. Same load with byte_valid_i toggling 1,0,0,1,... -> identical writes and data; no byte dropped or duplicated; byte_ready_o=0 during each WRITE cycle.
4. word_cnt_i=0, then word_cnt_i=33 -> err_o=1, no wr_en_o, byte_ready_o stays 0; a following start with count 1 clears err_o.
5. Full load with count 32 -> 32 writes at addresses 0x0..0x7C with no gaps beyond the WRITE cycles; start_i pulsed mid-load is ignored.
6. rst_i asserted after 2 bytes of word 3 -> no write for word 3, outputs return to reset values; a following load with count 1 writes address 0x0 with fresh data.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Program loader for the instruction store.
// Takes a byte stream over a valid/ready handshake, packs four bytes per
// 32-bit instruction with the first byte most significant, and writes the
// words to consecutive word-aligned byte addresses starting at 0. The CPU is
// held in reset for as long as a load is in progress.
module instr_mem_loader #(
    parameter int MEM_WORDS = 32,
    parameter int CNT_W     = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] word_cnt_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    output logic             wr_en_o,
    output logic [31:0]      wr_addr_o,
    output logic [31:0]      wr_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             cpu_hold_o
);

    localparam int               IDX_W   = $clog2(MEM_WORDS);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;       // latched number of words to load
    logic [IDX_W-1:0] idx_q, idx_d;       // index of the word being assembled
    logic [1:0]       bcnt_q, bcnt_d;     // bytes taken for the current word
    logic [23:0]      shift_q, shift_d;   // first three bytes of the word
    logic             ready_q, ready_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             start_ok;
    logic             xfer;
    logic [CNT_W-1:0] idx_next;

    assign start_ok = (word_cnt_i != '0) && (word_cnt_i <= MAX_CNT);
    assign xfer     = byte_valid_i && ready_q;
    // Compared at count width so a full load (count == MEM_WORDS) still matches.
    assign idx_next = CNT_W'(idx_q) + CNT_W'(1);

    // Next-state and registered-output logic for the load sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    done_d = 1'b0;
                    if (start_ok) begin
                        cnt_d   = word_cnt_i;
                        err_d   = 1'b0;
                        bcnt_d  = '0;
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    shift_d = {shift_q[15:0], byte_i};
                    // Wraps to 0 on the fourth byte, ready for the next word.
                    bcnt_d  = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = {{(32-IDX_W-2){1'b0}}, idx_q, 2'b00};
                        data_d  = {shift_q, byte_i};
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                bcnt_d = '0;
                // The index stops at the last word, so it never passes MEM_WORDS-1.
                if (idx_next == cnt_q) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = LOAD;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == LOAD);
        busy_d  = (state_d == LOAD) || (state_d == WRITE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign wr_en_o      = we_q;
    assign wr_addr_o    = addr_q;
    assign wr_data_o    = data_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign cpu_hold_o   = busy_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed loads plus randomized byte data and
// handshake gaps, checked against a word-packing model of the byte stream.
module tb_instr_mem_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [5:0]  word_cnt_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        wr_en_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        cpu_hold_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] stim[$];

    always #5 clk_i = ~clk_i;

    instr_mem_loader #(.MEM_WORDS(32), .CNT_W(6)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .word_cnt_i   (word_cnt_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .cpu_hold_o   (cpu_hold_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: inputs were set at the falling edge, outputs read at the next.
    task automatic cyc();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
        check({tag, "_wr_en"}, {31'd0, wr_en_o}, 32'd0);
        check({tag, "_addr"}, wr_addr_o, 32'd0);
        check({tag, "_data"}, wr_data_o, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_done"}, {31'd0, done_o}, 32'd0);
        check({tag, "_err"}, {31'd0, err_o}, 32'd0);
        check({tag, "_hold"}, {31'd0, cpu_hold_o}, 32'd0);
    endtask

    // Reference: word k is bytes 4k..4k+3 of the stream, first byte on top.
    function automatic logic [31:0] model_word(input int k);
        return {stim[4*k], stim[4*k+1], stim[4*k+2], stim[4*k+3]};
    endfunction

    // Runs one load of cnt words from stim.
    // mode 0: valid always high; 1: valid pattern 1,0,0 repeating; 2: random.
    // pulse_at: loop iteration at which a stray start is pulsed (0 = none).
    // abort_at: total bytes after which reset is asserted (0 = none).
    task automatic run_load(input int cnt, input int mode, input int pulse_at, input int abort_at);
        int   idx;
        int   written;
        int   iter;
        int   took;
        logic v;
        logic xfer;
        logic exp_we;
        idx     = 0;
        written = 0;
        iter    = 0;
        took    = 0;
        start_i      = 1'b1;
        word_cnt_i   = cnt[5:0];
        byte_valid_i = 1'b0;
        cyc();
        start_i = 1'b0;
        check("start_busy", {31'd0, busy_o}, 32'd1);
        check("start_ready", {31'd0, byte_ready_o}, 32'd1);
        check("start_err", {31'd0, err_o}, 32'd0);
        check("start_done", {31'd0, done_o}, 32'd0);

        while (written < cnt && iter < 4000) begin
            iter++;
            case (mode)
                0:       v = 1'b1;
                1:       v = (iter % 3 == 1);
                default: v = 1'($urandom_range(0, 1));
            endcase
            byte_valid_i = v && (idx < stim.size());
            byte_i       = (idx < stim.size()) ? stim[idx] : 8'h00;
            if (iter == pulse_at) begin
                start_i    = 1'b1;
                word_cnt_i = 6'd1;
            end else begin
                start_i = 1'b0;
            end
            xfer = byte_valid_i && byte_ready_o;
            cyc();
            if (xfer) begin
                idx++;
                took++;
            end
            exp_we = xfer && (took % 4 == 0);

            if (abort_at > 0 && took == abort_at) begin
                start_i      = 1'b0;
                rst_i        = 1'b1;
                byte_valid_i = 1'b1;
                check("abort_no_write", {31'd0, wr_en_o}, 32'd0);
                cyc();
                rst_i = 1'b0;
                check_zero("abort_rst");
                cyc();
                check_zero("abort_after");
                byte_valid_i = 1'b0;
                return;
            end

            check("wr_en_timing", {31'd0, wr_en_o}, {31'd0, exp_we});
            check("hold_eq_busy", {31'd0, cpu_hold_o}, {31'd0, busy_o});
            check("busy_in_load", {31'd0, busy_o}, 32'd1);
            if (wr_en_o) begin
                check("wr_addr", wr_addr_o, 32'(4 * written));
                check("wr_data", wr_data_o, model_word(written));
                check("ready_in_write", {31'd0, byte_ready_o}, 32'd0);
                written++;
            end
        end
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        check("words_written", 32'(written), 32'(cnt));
        check("bytes_consumed", 32'(idx), 32'(4 * cnt));
        if (mode == 0)
            check("load_cycles", 32'(iter), 32'(5 * cnt - 1));
        cyc();
        check("end_busy", {31'd0, busy_o}, 32'd0);
        check("end_hold", {31'd0, cpu_hold_o}, 32'd0);
        check("end_wr_en", {31'd0, wr_en_o}, 32'd0);
        check("end_ready", {31'd0, byte_ready_o}, 32'd0);
        cyc();
        check("end_done", {31'd0, done_o}, 32'd1);
        check("end_err", {31'd0, err_o}, 32'd0);
        check("end_busy2", {31'd0, busy_o}, 32'd0);
        check("end_wr_en2", {31'd0, wr_en_o}, 32'd0);
    endtask

    task automatic fill_random(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
    endtask

    task automatic reject_start(input logic [5:0] cnt, input string tag);
        start_i    = 1'b1;
        word_cnt_i = cnt;
        cyc();
        start_i      = 1'b0;
        byte_valid_i = 1'b1;
        byte_i       = 8'h5A;
        check({tag, "_err"}, {31'd0, err_o}, 32'd1);
        check({tag, "_done"}, {31'd0, done_o}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check({tag, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
            check({tag, "_wr_en"}, {31'd0, wr_en_o}, 32'd0);
            check({tag, "_err_hold"}, {31'd0, err_o}, 32'd1);
        end
        byte_valid_i = 1'b0;
    endtask

    initial begin
        rst_i        = 1'b1;
        start_i      = 1'b0;
        word_cnt_i   = 6'd0;
        byte_i       = 8'hAA;
        byte_valid_i = 1'b1;

        // Reset for two cycles with the stream offering bytes.
        @(negedge clk_i);
        cyc();
        check_zero("rst1");
        cyc();
        check_zero("rst2");
        rst_i = 1'b0;
        cyc();
        check_zero("idle_after_rst");
        byte_valid_i = 1'b0;

        // Two-word load, valid held high.
        stim = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h22, 8'h18, 8'h2A};
        run_load(2, 0, 0, 0);

        // Same load with gaps on the valid line.
        run_load(2, 1, 0, 0);

        // Rejected starts: zero and over-range counts, then a good start.
        reject_start(6'd0, "rej0");
        reject_start(6'd33, "rej33");
        fill_random(4);
        run_load(1, 2, 0, 0);

        // Full memory load with a stray start mid-load.
        fill_random(128);
        run_load(32, 0, 50, 0);

        // Random-length load with random handshake gaps.
        begin
            int n;
            n = int'($urandom_range(1, 32));
            fill_random(4 * n);
            run_load(n, 2, 0, 0);
        end

        // Reset after two bytes of word 3, then a fresh one-word load.
        fill_random(20);
        run_load(5, 2, 0, 14);
        fill_random(4);
        run_load(1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
